// File: rtl/mac_pkg.sv
// ============================================================================
// Module      : mac_pkg
// Description : Shared defaults, mac_col instruction codes and sequencer states
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mac_pkg;

    localparam int BW_DEF          = 8;
    localparam int PR_DEF          = 16;
    localparam int BW_PSUM_DEF     = 2 * BW_DEF + 4;
    localparam int TOTAL_CYCLE_DEF = 8;
    localparam int MAC_LAT_DEF     = 2;

    localparam logic [1:0] INST_NOP   = 2'b00;
    localparam logic [1:0] INST_KLOAD = 2'b01;
    localparam logic [1:0] INST_QEXEC = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KLOAD = 3'd1,
        ST_GAP   = 3'd2,
        ST_EXEC  = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mac_qbuf.sv
// ============================================================================
// Module      : mac_qbuf
// Description : Synchronous FIFO holding the Q vectors of one job
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mac_qbuf #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [$clog2(DEPTH+1)-1:0] count_next
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             w_wr;
    logic             w_rd;

    assign w_wr    = wr_en && (count != CNT_W'(DEPTH));
    assign w_rd    = rd_en && (count != '0);
    assign rd_data = r_mem[r_rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (w_wr && !w_rd) begin
            count_next = count + 1'b1;
        end else if (!w_wr && w_rd) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            count    <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
            count <= count_next;
        end
    end

    // Storage is never read before being written, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule

`default_nettype wire

// File: rtl/mac_col_seq.sv
// ============================================================================
// Module      : mac_col_seq
// Description : Job sequencer for one mac_col column (K load, Q stream, psum
//               capture). Optional sticky err output under MAC_COL_SEQ_ERR_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mac_col_seq
    import mac_pkg::*;
#(
    parameter int BW          = BW_DEF,
    parameter int BW_PSUM     = BW_PSUM_DEF,
    parameter int PR          = PR_DEF,
    parameter int TOTAL_CYCLE = TOTAL_CYCLE_DEF,
    parameter int MAC_LAT     = MAC_LAT_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [PR*BW-1:0]               k_in,
    input  logic                           q_wr,
    input  logic [PR*BW-1:0]               q_data,
    output logic                           q_full,
    output logic                           busy,
    output logic [PR*BW-1:0]               mac_q,
    output logic [1:0]                     mac_inst,
    input  logic [BW_PSUM-1:0]             mac_out,
    output logic                           res_valid,
    output logic [BW_PSUM-1:0]             res_data,
    output logic [$clog2(TOTAL_CYCLE)-1:0] res_idx,
`ifdef MAC_COL_SEQ_ERR_EN
    output logic                           err,
`endif
    output logic                           done
);

    localparam int DW     = PR * BW;
    localparam int IDX_W  = $clog2(TOTAL_CYCLE);
    localparam int CNT_W  = $clog2(TOTAL_CYCLE + MAC_LAT + 1);
    localparam int FCNT_W = $clog2(TOTAL_CYCLE + 1);
    localparam logic [CNT_W-1:0]  EXEC_LAST = CNT_W'(TOTAL_CYCLE + MAC_LAT - 1);
    localparam logic [FCNT_W-1:0] FULL_CNT  = FCNT_W'(TOTAL_CYCLE);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_start_ok;
    logic               w_wr_en;
    logic               w_rd_en;
    logic               w_clear;
    logic [DW-1:0]      w_rd_data;
    logic [FCNT_W-1:0]  w_fcount;
    logic [FCNT_W-1:0]  w_fcount_next;
    logic [1:0]         w_inst_next;
    logic [DW-1:0]      w_q_next;
    logic               w_res_valid_next;

    assign w_start_ok = start && (r_state == ST_IDLE) && (w_fcount == FULL_CNT);
    assign w_wr_en    = q_wr && !q_full;
    assign w_clear    = (r_state == ST_FIN);

    mac_qbuf #(
        .WIDTH (DW),
        .DEPTH (TOTAL_CYCLE)
    ) u_qbuf (
        .clk        (clk),
        .reset      (reset),
        .clear      (w_clear),
        .wr_en      (w_wr_en),
        .wr_data    (q_data),
        .rd_en      (w_rd_en),
        .rd_data    (w_rd_data),
        .count      (w_fcount),
        .count_next (w_fcount_next)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_next = ST_KLOAD;
                    w_cnt_next   = '0;
                end
            end
            ST_KLOAD: begin
                w_state_next = ST_GAP;
                w_cnt_next   = '0;
            end
            ST_GAP: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = ST_EXEC;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_EXEC: begin
                if (r_cnt == EXEC_LAST) begin
                    w_state_next = ST_FIN;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_FIN:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they can be registered
    // without adding a cycle of latency.
    always_comb begin
        w_inst_next = INST_NOP;
        w_q_next    = '0;
        w_rd_en     = 1'b0;
        case (w_state_next)
            ST_KLOAD: begin
                w_inst_next = INST_KLOAD;
                w_q_next    = k_in;
            end
            ST_GAP:   w_q_next = mac_q;
            ST_EXEC: begin
                w_inst_next = INST_QEXEC;
                if (w_cnt_next < CNT_W'(TOTAL_CYCLE)) begin
                    w_q_next = w_rd_data;
                    w_rd_en  = 1'b1;
                end
            end
            default: ;
        endcase
        w_res_valid_next = (r_state == ST_EXEC) && (r_cnt >= CNT_W'(MAC_LAT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            mac_inst  <= INST_NOP;
            mac_q     <= '0;
            busy      <= 1'b0;
            q_full    <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
            done      <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            mac_inst  <= w_inst_next;
            mac_q     <= w_q_next;
            busy      <= (w_state_next != ST_IDLE);
            q_full    <= (w_fcount_next == FULL_CNT) || (w_state_next != ST_IDLE);
            res_valid <= w_res_valid_next;
            res_data  <= w_res_valid_next ? mac_out : '0;
            res_idx   <= w_res_valid_next ? IDX_W'(r_cnt - CNT_W'(MAC_LAT)) : '0;
            done      <= (w_state_next == ST_FIN);
        end
    end

`ifdef MAC_COL_SEQ_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if ((start && (r_state == ST_IDLE) && (w_fcount != FULL_CNT)) ||
                     (start && busy) || (q_wr && q_full)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire
